// File: rtl/frodo_mat_pkg.sv
// Shared FrodoKEM matrix geometry and the HASH stripe writer state type.
package frodo_mat_pkg;

    localparam int unsigned FRODO_N    = 1344;
    localparam int unsigned ELEM_W     = 16;
    localparam int unsigned WORD_W     = 64;
    localparam int unsigned ROWS       = 4;
    localparam int unsigned ROW_WORDS  = FRODO_N * ELEM_W / WORD_W;
    localparam int unsigned ROW_STRIDE = FRODO_N * ELEM_W;
    localparam int unsigned BANK_BIAS  = ROWS * ROW_STRIDE;
    localparam int unsigned STRIPES    = FRODO_N / ROWS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STALL,
        DRAIN
    } hsw_state_t;

endpackage

// File: rtl/hsw_addr_gen.sv
// Row-major word/row counters for one stripe and the HASH BRAM bit address they map to.
module hsw_addr_gen #(
    parameter int unsigned WORD_W     = frodo_mat_pkg::WORD_W,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ROW_WORDS  = frodo_mat_pkg::ROW_WORDS,
    parameter int unsigned ROWS       = frodo_mat_pkg::ROWS,
    parameter int unsigned ROW_STRIDE = frodo_mat_pkg::ROW_STRIDE,
    parameter int unsigned BANK_BIAS  = frodo_mat_pkg::BANK_BIAS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic              bank_i,
    output logic              stripe_last_o,
    output logic [ADDR_W-1:0] addr_o
);
    import frodo_mat_pkg::*;

    // Keep at least one bit so single-row / single-word geometries still elaborate.
    localparam int unsigned WordCntW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int unsigned RowCntW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [WordCntW-1:0] WordLast = WordCntW'(ROW_WORDS - 1);
    localparam logic [RowCntW-1:0]  RowLast  = RowCntW'(ROWS - 1);

    logic [WordCntW-1:0] word_q, word_d;
    logic [RowCntW-1:0]  row_q, row_d;
    logic                word_wrap;

    assign word_wrap     = (word_q == WordLast);
    assign stripe_last_o = word_wrap && (row_q == RowLast);

    assign addr_o = (bank_i ? ADDR_W'(BANK_BIAS) : '0)
                  + ADDR_W'(row_q) * ADDR_W'(ROW_STRIDE)
                  + ADDR_W'(word_q) * ADDR_W'(WORD_W);

    // Advance word first, then row; wrap to the start of the next stripe.
    always_comb begin
        word_d = word_q;
        row_d  = row_q;
        if (clear_i) begin
            word_d = '0;
            row_d  = '0;
        end else if (step_i) begin
            if (word_wrap) begin
                word_d = '0;
                row_d  = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                word_d = word_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            row_q  <= '0;
        end else begin
            word_q <= word_d;
            row_q  <= row_d;
        end
    end

endmodule

// File: rtl/hash_stripe_writer.sv
// HASH BRAM writer: streams A-matrix words into two ping-pong stripe banks and
// hands full banks to the matrix controller. Optional protocol checking is built
// only when HASH_STRIPE_CHECK_EN is defined.
module hash_stripe_writer #(
    parameter int unsigned WORD_W     = frodo_mat_pkg::WORD_W,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ROW_WORDS  = frodo_mat_pkg::ROW_WORDS,
    parameter int unsigned ROWS       = frodo_mat_pkg::ROWS,
    parameter int unsigned ROW_STRIDE = frodo_mat_pkg::ROW_STRIDE,
    parameter int unsigned BANK_BIAS  = frodo_mat_pkg::BANK_BIAS,
    parameter int unsigned STRIPES    = frodo_mat_pkg::STRIPES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WORD_W-1:0] wr_data_o,
    output logic              hash_ready_o,
    output logic              hash_bank_o,
    input  logic              block_consumed_i,
    output logic [8:0]        stripe_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    import frodo_mat_pkg::*;

    localparam logic [8:0] StripeLast = 9'(STRIPES - 1);

    hsw_state_t        state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              last_q, last_d;
    logic              last_bank_q, last_bank_d;
    logic [8:0]        stripe_cnt_q, stripe_cnt_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;

    logic              in_ready;
    logic              hs;
    logic              hash_ready;
    logic              consume;
    logic              launch;
    logic              stripe_last;
    logic              stripe_done;
    logic              drain_done;
    logic [ADDR_W-1:0] gen_addr;

    assign in_ready    = (state_q == FILL) && !bank_full_q[wr_bank_q];
    assign hs          = in_valid_i && in_ready;
    assign hash_ready  = bank_full_q[rd_bank_q];
    assign consume     = block_consumed_i && hash_ready;
    assign launch      = (state_q == IDLE) && start_i;
    assign stripe_done = hs && stripe_last;

    hsw_addr_gen #(
        .WORD_W     (WORD_W),
        .ADDR_W     (ADDR_W),
        .ROW_WORDS  (ROW_WORDS),
        .ROWS       (ROWS),
        .ROW_STRIDE (ROW_STRIDE),
        .BANK_BIAS  (BANK_BIAS)
    ) u_addr_gen (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (launch),
        .step_i        (hs),
        .bank_i        (wr_bank_q),
        .stripe_last_o (stripe_last),
        .addr_o        (gen_addr)
    );

    // Bank bookkeeping: the finished bank is marked full one edge after its last
    // word is accepted, so hash_ready cannot run ahead of the final BRAM write.
    always_comb begin
        bank_full_d  = bank_full_q;
        rd_bank_d    = rd_bank_q;
        wr_bank_d    = wr_bank_q;
        last_d       = stripe_done;
        last_bank_d  = stripe_done ? wr_bank_q : last_bank_q;
        stripe_cnt_d = stripe_cnt_q;
        if (consume) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
        if (last_q) begin
            bank_full_d[last_bank_q] = 1'b1;
            stripe_cnt_d             = stripe_cnt_q + 9'd1;
        end
        if (stripe_done) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (launch) begin
            wr_bank_d    = 1'b0;
            rd_bank_d    = 1'b0;
            stripe_cnt_d = '0;
        end
    end

    // Next-state: STALL/FILL decisions look at next-cycle bank flags so a consume
    // reopens the stream on the very edge it lands.
    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = FILL;
            end
            FILL: begin
                if (stripe_done) begin
                    if (stripe_cnt_q == StripeLast) begin
                        state_d = DRAIN;
                    end else if (bank_full_d[~wr_bank_q]) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!bank_full_d[wr_bank_q]) state_d = FILL;
            end
            DRAIN: begin
                // last_q guards the cycle before the final bank is flagged full.
                if (bank_full_q == 2'b00 && !last_q) begin
                    state_d    = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, bank flags and the one-cycle-latency BRAM write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bank_full_q  <= 2'b00;
            last_q       <= 1'b0;
            last_bank_q  <= 1'b0;
            stripe_cnt_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            bank_full_q  <= bank_full_d;
            last_q       <= last_d;
            last_bank_q  <= last_bank_d;
            stripe_cnt_q <= stripe_cnt_d;
            wr_en_q      <= hs;
            if (hs) begin
                wr_addr_q <= gen_addr;
                wr_data_q <= in_data_i;
            end
        end
    end

`ifdef HASH_STRIPE_CHECK_EN
    logic err_q, err_d;

    // Sticky flag for consumer/producer protocol violations.
    always_comb begin
        err_d = err_q | (block_consumed_i & ~hash_ready) | (in_valid_i & (state_q == IDLE));
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign in_ready_o   = in_ready;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign hash_ready_o = hash_ready;
    assign hash_bank_o  = rd_bank_q;
    assign stripe_cnt_o = stripe_cnt_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = drain_done;

endmodule
